// File: rtl/intro_topp1_if.sv
// Functional and scan-control signal bundle for the intro DFT lab core.
// The master side drives mode, scan data and A..D; the slave side (the core) returns X/Y/Z.
interface intro_topp1_if;
    logic i_scanMode;
    logic i_scanIn;
    logic i_a;
    logic i_b;
    logic i_c;
    logic i_d;
    logic o_x;
    logic o_y;
    logic o_z;

    modport master (
        output i_scanMode, i_scanIn, i_a, i_b, i_c, i_d,
        input  o_x, o_y, o_z
    );

    modport slave (
        input  i_scanMode, i_scanIn, i_a, i_b, i_c, i_d,
        output o_x, o_y, o_z
    );
endinterface

// File: rtl/intro_topp1.sv
// Intro DFT lab core: registered A..D inputs, fixed X/Y/Z logic, registered outputs.
// All seven flops double as one serial scan chain ScanIn -> ar..dr -> xr -> yr -> zr.
module intro_topp1 (
    input  logic          i_scanClk,
    input  logic          i_scanClr,
    intro_topp1_if.slave  bus
);

    logic r_ar, r_br, r_cr, r_dr;
    logic r_xr, r_yr, r_zr;
    logic w_andAB;
    logic w_orCD;

    assign w_andAB = r_ar & r_br;
    assign w_orCD  = r_cr | r_dr;

    // Clear beats scan, scan beats capture; the last chain bit (zr) simply falls off.
    always_ff @(posedge i_scanClk) begin
        if (!i_scanClr) begin
            r_ar <= 1'b0;
            r_br <= 1'b0;
            r_cr <= 1'b0;
            r_dr <= 1'b0;
            r_xr <= 1'b0;
            r_yr <= 1'b0;
            r_zr <= 1'b0;
        end else if (bus.i_scanMode) begin
            r_ar <= bus.i_scanIn;
            r_br <= r_ar;
            r_cr <= r_br;
            r_dr <= r_cr;
            r_xr <= r_dr;
            r_yr <= r_xr;
            r_zr <= r_yr;
        end else begin
            r_ar <= bus.i_a;
            r_br <= bus.i_b;
            r_cr <= bus.i_c;
            r_dr <= bus.i_d;
            r_xr <= ~w_andAB;
            r_yr <= w_orCD;
            r_zr <= w_andAB ^ w_orCD;
        end
    end

    assign bus.o_x = r_xr;
    assign bus.o_y = r_yr;
    assign bus.o_z = r_zr;

endmodule

// File: tb/tb_intro_topp1.sv
// Self-checking bench for intro_topp1: a seven-bit behavioural model checked every cycle,
// plus hand-computed directed cases for reset, scan timing, truth values and latency.
module tb_intro_topp1;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    int   cycleNo;

    intro_topp1_if bus ();

    intro_topp1 dut (
        .i_scanClk (clk),
        .i_scanClr (clr),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state as a chain vector: index 0 = ar ... 6 = zr.
    logic [6:0] mChain;
    bit         modelValid;

    initial begin
        mChain     = '0;
        modelValid = 1'b0;
        cycleNo    = 0;
    end

    always @(posedge clk) begin
        logic p;
        logic q;
        cycleNo = cycleNo + 1;
        if (!clr) begin
            mChain     = '0;
            modelValid = 1'b1;
        end else if (bus.i_scanMode) begin
            mChain = {mChain[5:0], bus.i_scanIn};
        end else begin
            p = mChain[0] & mChain[1];
            q = mChain[2] | mChain[3];
            mChain = {p ^ q, q, ~p, bus.i_d, bus.i_c, bus.i_b, bus.i_a};
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checks = checks + 1;
            if ({bus.o_x, bus.o_y, bus.o_z} !== {mChain[4], mChain[5], mChain[6]}) begin
                failures = failures + 1;
                $display("[TB] FAIL model_cmp cycle=%0d got XYZ=%b%b%b expected %b%b%b",
                         cycleNo, bus.o_x, bus.o_y, bus.o_z, mChain[4], mChain[5], mChain[6]);
            end
        end
    end

    task automatic applyStimulus(input logic vClr, input logic vMode, input logic vIn,
                                 input logic vA, input logic vB, input logic vC, input logic vD);
        clr            = vClr;
        bus.i_scanMode = vMode;
        bus.i_scanIn   = vIn;
        bus.i_a        = vA;
        bus.i_b        = vB;
        bus.i_c        = vC;
        bus.i_d        = vD;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic ex, input logic ey, input logic ez);
        checks = checks + 1;
        if ({bus.o_x, bus.o_y, bus.o_z} !== {ex, ey, ez}) begin
            failures = failures + 1;
            $display("[TB] FAIL %s got XYZ=%b%b%b expected %b%b%b",
                     name, bus.o_x, bus.o_y, bus.o_z, ex, ey, ez);
        end
    endtask

    task automatic randomFunctional(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom));
    endtask

    logic [3:0] tv [4];
    logic [2:0] tx [4];

    initial begin
        checks   = 0;
        failures = 0;
        clr            = 1'b1;
        bus.i_scanMode = 1'b0;
        bus.i_scanIn   = 1'b0;
        bus.i_a        = 1'b0;
        bus.i_b        = 1'b0;
        bus.i_c        = 1'b0;
        bus.i_d        = 1'b0;
        @(negedge clk);

        // Reset in functional mode, then in scan mode, each from a random state.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        randomFunctional(5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("reset_func", 1'b0, 1'b0, 1'b0);
        randomFunctional(5);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("reset_scan", 1'b0, 1'b0, 1'b0);

        // Single 1 walking through the chain.
        for (int e = 1; e <= 9; e++) begin
            applyStimulus(1'b1, 1'b1, (e == 1), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom));
            checkOutput($sformatf("scan_walk_e%0d", e), (e == 5), (e == 6), (e == 7));
        end

        // Functional truth values, inputs held two edges: {A,B,C,D} -> {X,Y,Z}.
        tv[0] = 4'b0000; tx[0] = 3'b100;
        tv[1] = 4'b1100; tx[1] = 3'b001;
        tv[2] = 4'b0111; tx[2] = 3'b111;
        tv[3] = 4'b1111; tx[3] = 3'b010;
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, 1'b0, 1'($urandom), tv[t][3], tv[t][2], tv[t][1], tv[t][0]);
            applyStimulus(1'b1, 1'b0, 1'($urandom), tv[t][3], tv[t][2], tv[t][1], tv[t][0]);
            checkOutput($sformatf("truth_%b", tv[t]), tx[t][2], tx[t][1], tx[t][0]);
        end

        // Scan-load ar=br=1, cr=dr=0, then one capture edge with random A..D.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        checkOutput("scan_capture", 1'b0, 1'b0, 1'b1);

        // Mid-shift clear discards the partially shifted pattern.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) begin
            applyStimulus(1'b1, 1'b1, (e % 2 == 0), 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("midclr_pre%0d", e), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midclr_clear", 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 7; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("midclr_post%0d", e), 1'b0, 1'b0, 1'b0);
        end

        // Latency: A falls with B=1, X rises exactly on the second edge.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("latency_before", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("latency_edge1", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("latency_edge2", 1'b1, 1'b0, 1'b0);

        // Random mix of modes and occasional clears, checked by the model process.
        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
